// File: rtl/decimator.sv
// Block-averaging decimator: sums N signed samples and emits the floored mean
// through a one-entry output register with valid/ready handshakes on both sides.
module decimator #(
   parameter int W = 16,
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         x_valid,
   output logic         x_ready,
   input  logic [W-1:0] x_data,
   output logic         y_valid,
   input  logic         y_ready,
   output logic [W-1:0] y_data
);

   localparam int L = $clog2(N);
   localparam logic [L-1:0] CNT_LAST = L'(N - 1);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t                state, state_nxt;
   logic [L-1:0]          cnt;
   logic signed [W+L-1:0] acc;
   logic signed [W+L-1:0] sum;
   logic                  x_fire, y_fire, blk_done;

   assign y_valid  = (state == FULL);
   // The last sample of a block may only enter when the output slot frees up.
   assign x_ready  = (cnt != CNT_LAST) || !y_valid || y_ready;
   assign x_fire   = x_valid && x_ready;
   assign y_fire   = y_valid && y_ready;
   assign blk_done = x_fire && (cnt == CNT_LAST);
   assign sum      = acc + {{L{x_data[W-1]}}, x_data};

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (blk_done) state_nxt = FULL;
         FULL:    if (!blk_done && y_fire) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= EMPTY;
         cnt    <= '0;
         acc    <= '0;
         y_data <= '0;
      end else begin
         state <= state_nxt;
         if (x_fire) begin
            // N is a power of two, so the L-bit counter wraps on its own.
            cnt <= cnt + 1'b1;
            if (blk_done) begin
               acc    <= '0;
               y_data <= W'(sum >>> L);
            end else begin
               acc <= sum;
            end
         end
      end
   end

endmodule

// File: tb/tb_decimator.sv
// Bench for decimator (W=16, N=4): directed block table, backpressure and reset
// sequences, then a random valid/ready soak against a per-block average model.
module tb_decimator;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        x_valid = 1'b0;
   logic        x_ready;
   logic [15:0] x_data = '0;
   logic        y_valid;
   logic        y_ready = 1'b0;
   logic [15:0] y_data;

   decimator #(.W(16), .N(4)) dut (
      .clk(clk), .reset(reset),
      .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
      .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [15:0] q[$];
   int          msum = 0;
   int          mcnt = 0;
   logic        mvalid = 1'b0;
   int          n_in = 0;
   int          n_out = 0;

   typedef struct {
      int x0, x1, x2, x3;
      int exp;
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, check outputs at the falling edge, advance the model.
   task automatic cyc(input logic xv, input logic [15:0] xd, input logic yr);
      logic exr, xf, yf;
      x_valid = xv; x_data = xd; y_ready = yr;
      @(negedge clk);
      exr = (mcnt != 3) || !mvalid || yr;
      if (reset) begin
         chk("y_valid", {31'd0, y_valid}, {31'd0, mvalid});
         chk("x_ready", {31'd0, x_ready}, {31'd0, exr});
         if (mvalid) chk("y_data", {16'd0, y_data}, {16'd0, q[0]});
         xf = xv && exr;
         yf = mvalid && yr;
         if (yf) begin
            void'(q.pop_front());
            n_out++;
         end
         if (xf) begin
            n_in++;
            msum += int'($signed(xd));
            mcnt++;
            if (mcnt == 4) begin
               q.push_back(16'(msum >>> 2));
               msum = 0; mcnt = 0; mvalid = 1'b1;
            end else if (yf) mvalid = 1'b0;
         end else if (yf) mvalid = 1'b0;
      end else begin
         q.delete(); msum = 0; mcnt = 0; mvalid = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc(1'b0, 16'd0, 1'b0);
      reset = 1'b1;
   endtask

   initial begin
      int cycles;
      vecs[0] = '{1, 2, 3, 4, 2};
      vecs[1] = '{-1, -2, -3, -4, -3};
      vecs[2] = '{32767, 32767, 32767, 32767, 32767};
      vecs[3] = '{-32768, -32768, -32768, -32768, -32768};
      vecs[4] = '{0, 0, 0, 3, 0};
      vecs[5] = '{-1, 0, 0, 0, -1};
      vecs[6] = '{100, -50, 7, 8, 16};

      // reset state
      reset = 1'b0;
      cyc(1'b0, 16'd0, 1'b0);
      cyc(1'b0, 16'd0, 1'b0);
      chk("rst_y_valid", {31'd0, y_valid}, 32'd0);
      chk("rst_y_data", {16'd0, y_data}, 32'd0);
      chk("rst_x_ready", {31'd0, x_ready}, 32'd1);
      reset = 1'b1;

      // table of whole blocks, y_ready held high
      foreach (vecs[i]) begin
         cyc(1'b1, 16'(vecs[i].x0), 1'b1);
         cyc(1'b1, 16'(vecs[i].x1), 1'b1);
         cyc(1'b1, 16'(vecs[i].x2), 1'b1);
         chk($sformatf("vec%0d_not_yet", i), {31'd0, y_valid}, 32'd0);
         cyc(1'b1, 16'(vecs[i].x3), 1'b1);
         chk($sformatf("vec%0d_valid", i), {31'd0, y_valid}, 32'd1);
         chk($sformatf("vec%0d_data", i), {16'd0, y_data}, {16'd0, 16'(vecs[i].exp)});
         cyc(1'b0, 16'd0, 1'b1);
         chk($sformatf("vec%0d_one_cycle", i), {31'd0, y_valid}, 32'd0);
      end

      // backpressure: result 5 held while next block fills
      for (int k = 0; k < 4; k++) cyc(1'b1, 16'd5, 1'b1);
      chk("bp_first", {16'd0, y_data}, 32'd5);
      for (int k = 0; k < 3; k++) cyc(1'b1, 16'd6, 1'b0);
      x_valid = 1'b1; x_data = 16'd6; y_ready = 1'b0; #1;
      chk("bp_stall_xr", {31'd0, x_ready}, 32'd0);
      chk("bp_hold_data", {16'd0, y_data}, 32'd5);
      cyc(1'b1, 16'd6, 1'b0);
      cyc(1'b1, 16'd6, 1'b0);
      chk("bp_still_5", {16'd0, y_data}, 32'd5);
      chk("bp_still_valid", {31'd0, y_valid}, 32'd1);
      cyc(1'b1, 16'd6, 1'b1);
      chk("bp_next_valid", {31'd0, y_valid}, 32'd1);
      chk("bp_next_data", {16'd0, y_data}, 32'd6);
      for (int k = 0; k < 4; k++) cyc(1'b1, 16'd7, 1'b1);
      chk("bp_third", {16'd0, y_data}, 32'd7);
      cyc(1'b0, 16'd0, 1'b1);
      chk("bp_drained", {31'd0, y_valid}, 32'd0);

      // reset mid-block discards 7 and 9
      cyc(1'b1, 16'd7, 1'b1);
      cyc(1'b1, 16'd9, 1'b1);
      do_reset();
      x_valid = 1'b1; x_data = 16'd4; y_ready = 1'b1; #1;
      chk("mid_rst_xr", {31'd0, x_ready}, 32'd1);
      for (int k = 0; k < 4; k++) cyc(1'b1, 16'd4, 1'b1);
      chk("mid_rst_data", {16'd0, y_data}, 32'd4);
      cyc(1'b0, 16'd0, 1'b1);

      // reset while FULL drops the pending output
      for (int k = 0; k < 4; k++) cyc(1'b1, 16'd9, 1'b0);
      chk("full_before_rst", {31'd0, y_valid}, 32'd1);
      do_reset();
      chk("full_rst_valid", {31'd0, y_valid}, 32'd0);
      chk("full_rst_data", {16'd0, y_data}, 32'd0);

      // random soak
      n_in = 0; n_out = 0; cycles = 0;
      while (n_in < 10000 && cycles < 60000) begin
         cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
         cycles++;
      end
      chk("rand_in_done", 32'(n_in), 32'd10000);
      for (int k = 0; k < 4; k++) cyc(1'b0, 16'd0, 1'b1);
      chk("rand_out_count", 32'(n_out), 32'd2500);
      chk("rand_q_empty", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decimator.md
DECIMATOR -- requirements
Module: decimator

Interface
REQ-001 SHALL have parameter W, default 16, meaning sample width in bits (signed two's complement, input and output).
REQ-002 SHALL have parameter N, default 4, meaning decimation factor; power of two, 2..256; L = log2(N).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port x_valid  input  1  upstream sample valid.
REQ-006 SHALL have port x_ready  output  1  block accepts x_data this cycle.
REQ-007 SHALL have port x_data  input  W  signed input sample.
REQ-008 SHALL have port y_valid  output  1  decimated sample valid; feeds the window stage.
REQ-009 SHALL have port y_ready  input  1  downstream accepts y_data this cycle.
REQ-010 SHALL have port y_data  output  W  signed decimated (block-averaged) sample.

Function
REQ-011 SHALL treat an input transfer as x_valid && x_ready and an output transfer as y_valid && y_ready, both on the same rising edge.
REQ-012 SHALL keep a phase counter cnt (0..N-1) that increments on each input transfer and wraps from N-1 to 0.
REQ-013 SHALL keep a signed accumulator acc of W+L bits; sign-extension only, so no overflow is possible.
REQ-014 SHALL, on an input transfer with cnt < N-1, set acc <= acc + x_data; output state is unchanged.
REQ-015 SHALL, on an input transfer with cnt == N-1, load the output register with (acc + x_data) arithmetic-shifted right by L (floor rounding), set acc <= 0 and cnt <= 0.
REQ-016 SHALL implement the output register as a two-state FSM: EMPTY (y_valid=0) and FULL (y_valid=1).
REQ-017 EMPTY -> FULL on the block-completing input transfer (REQ-015).
REQ-018 FULL -> EMPTY on an output transfer with no block-completing input in the same cycle.
REQ-019 FULL stays FULL with y_data replaced by the new result when an output transfer and a block-completing input occur in the same cycle.
REQ-020 FULL stays FULL with y_data unchanged while y_ready=0.
REQ-021 SHALL drive x_ready combinationally as (cnt != N-1) || !y_valid || y_ready.
  - Non-completing samples are never stalled.
  - The completing sample stalls only while the output is held.
REQ-022 SHALL hold y_data and y_valid stable from assertion until the output transfer.
REQ-023 Latency: y_valid SHALL rise on the clock edge that accepts the N-th sample of a block (visible the following cycle); no other pipeline delay.
REQ-024 SHALL sustain one input transfer per cycle and emit one output per N input transfers when y_ready is held high.
REQ-025 SHALL never drop or duplicate a block.
  - Each output corresponds to exactly N consecutive accepted inputs.
  - Blocks are aligned to the first accepted sample after reset.
REQ-026 SHALL ignore x_data when x_valid=0, and SHALL ignore y_ready when y_valid=0.

Reset
REQ-027 While reset=0 at a rising edge, SHALL set cnt=0, acc=0, FSM=EMPTY, y_valid=0 and y_data=0.
REQ-028 Reset asserted mid-block SHALL discard the partial accumulation; the next block starts with the first sample accepted after reset=1.
REQ-029 Reset asserted while FULL SHALL discard the pending output without a transfer.
REQ-030 SHALL drive x_ready=1 during and immediately after reset (cnt=0).

Verification (W=16, N=4)
REQ-031 SHALL test basic operation: y_ready=1; inputs 1,2,3,4 on consecutive cycles -> one output y_data=2 (10>>2), y_valid high exactly one cycle.
REQ-032 SHALL test negative floor rounding: inputs -1,-2,-3,-4 -> y_data=-3 (0xFFFD), since -10>>>2 = -3.
REQ-033 SHALL test extremes:
  - four inputs of 32767 -> y_data=32767.
  - four inputs of -32768 -> y_data=-32768.
  - no wrap in either case.
REQ-034 SHALL test backpressure:
  - Hold y_ready=0 after block 1 (result 5); stream 8 further samples.
  - Next 3 samples are accepted; x_ready=0 on the 4th; y_data stays 5.
  - Raise y_ready -> 5 transferred; the stalled sample is accepted the same cycle; the next result appears the following cycle.
REQ-035 SHALL test reset mid-block: accept 7, 9; pulse reset=0 for one cycle; then accept 4,4,4,4 -> y_data=4 (the 7 and 9 are excluded).
REQ-036 SHALL test sustained throughput: random x_valid/y_ready (50% each), 10000 samples -> outputs match a reference model of floor(sum/4) per block, with no loss or duplication.
